// File: rtl/log_position_detector_pipe.sv
// log_position_detector_pipe
//   Finds the leading-one index of an unsigned power sample and the FRAC_W
//   bits directly below it. It also emits {position, fraction} as a
//   Mitchell-style log2 estimate. A sideband tag travels with each sample.
//
//   Four register stages run under a single global stall:
//     S1  capture power/tag on accept
//     S2  per-group OR flags (coarse search)
//     S3  pick highest nonzero group, extract its window and base index
//     S4  fine priority inside the window -> position/precision (outputs)
//
//   Handshake: a transfer happens on a rising edge where valid and ready
//   are both high. The source holds valid_in and its data until ready_in
//   is high. The result holds valid_out and its data until ready_out is
//   high. ready_in = ~valid_out | ready_out. When it is low every stage
//   holds its state.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   valid_in/ready_in  input handshake; power_in, tag_in are the sample
//   valid_out/ready_out  output handshake
//   position_integer   bit index of the leading one (0 for zero input)
//   precision          FRAC_W bits below the leading one, zero-padded at LSB
//   log2_out           {position_integer, precision}
//   zero_out           sample was zero
//   tag_out            tag of the sample producing this result
//
// DATA_W must be a multiple of GROUP_W, and 1 <= FRAC_W <= DATA_W-1.
module log_position_detector_pipe #(
    parameter int DATA_W  = 32,
    parameter int GROUP_W = 4,
    parameter int FRAC_W  = 4,
    parameter int TAG_W   = 8,
    localparam int POS_W  = $clog2(DATA_W)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [DATA_W-1:0]       power_in,
    input  logic [TAG_W-1:0]        tag_in,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [POS_W-1:0]        position_integer,
    output logic [FRAC_W-1:0]       precision,
    output logic [POS_W+FRAC_W-1:0] log2_out,
    output logic                    zero_out,
    output logic [TAG_W-1:0]        tag_out
);
    localparam int NGRP  = DATA_W / GROUP_W;
    localparam int WIN_W = GROUP_W + FRAC_W;

    logic adv;
    assign adv      = ~valid_out | ready_out;
    assign ready_in = adv;

    // ---------------- S1: capture ----------------
    logic              s1_v;
    logic [DATA_W-1:0] s1_power;
    logic [TAG_W-1:0]  s1_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v     <= 1'b0;
            s1_power <= '0;
            s1_tag   <= '0;
        end else if (adv) begin
            s1_v     <= valid_in;
            s1_power <= power_in;
            s1_tag   <= tag_in;
        end
    end

    // ---------------- S2: group OR flags ----------------
    logic [NGRP-1:0]   grp_or_c;
    logic              s2_v;
    logic [NGRP-1:0]   s2_flags;
    logic [DATA_W-1:0] s2_power;
    logic [TAG_W-1:0]  s2_tag;

    always_comb begin
        grp_or_c = '0;
        for (int g = 0; g < NGRP; g++) begin
            grp_or_c[g] = |s1_power[g*GROUP_W +: GROUP_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v     <= 1'b0;
            s2_flags <= '0;
            s2_power <= '0;
            s2_tag   <= '0;
        end else if (adv) begin
            s2_v     <= s1_v;
            s2_flags <= grp_or_c;
            s2_power <= s1_power;
            s2_tag   <= s1_tag;
        end
    end

    // ---------------- S3: coarse priority encode ----------------
    // Padding FRAC_W zeros below the sample lets the window for the lowest
    // group read zeros instead of wrapping to the top of the word.
    logic [DATA_W+FRAC_W-1:0] padded_c;
    logic [WIN_W-1:0]         win_c;
    logic [POS_W-1:0]         base_c;
    logic                     s3_v;
    logic [WIN_W-1:0]         s3_win;
    logic [POS_W-1:0]         s3_base;
    logic                     s3_zero;
    logic [TAG_W-1:0]         s3_tag;

    always_comb begin
        padded_c = {s2_power, {FRAC_W{1'b0}}};
        win_c    = '0;
        base_c   = '0;
        // Ascending scan: the last hit is the highest nonzero group.
        for (int g = 0; g < NGRP; g++) begin
            if (s2_flags[g]) begin
                win_c  = padded_c[g*GROUP_W +: WIN_W];
                base_c = POS_W'(g * GROUP_W);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_v    <= 1'b0;
            s3_win  <= '0;
            s3_base <= '0;
            s3_zero <= 1'b0;
            s3_tag  <= '0;
        end else if (adv) begin
            s3_v    <= s2_v;
            s3_win  <= win_c;
            s3_base <= base_c;
            s3_zero <= ~|s2_flags;
            s3_tag  <= s2_tag;
        end
    end

    // ---------------- S4: fine priority, outputs ----------------
    // A zero sample leaves the window at zero, so offset and fraction
    // both fall out as zero with no special case.
    logic [POS_W-1:0]  off_c;
    logic [FRAC_W-1:0] prec_c;

    always_comb begin
        off_c  = '0;
        prec_c = '0;
        for (int k = 0; k < GROUP_W; k++) begin
            if (s3_win[FRAC_W+k]) begin
                off_c  = POS_W'(k);
                prec_c = s3_win[k +: FRAC_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out        <= 1'b0;
            position_integer <= '0;
            precision        <= '0;
            zero_out         <= 1'b0;
            tag_out          <= '0;
        end else if (adv) begin
            valid_out        <= s3_v;
            position_integer <= s3_base + off_c;
            precision        <= prec_c;
            zero_out         <= s3_zero;
            tag_out          <= s3_tag;
        end
    end

    assign log2_out = {position_integer, precision};

endmodule

// File: doc/log_position_detector_pipe.md
Name: log_position_detector_pipe

Overview:
- Parametrised, back-pressurable successor to the fixed 32-bit MSB/precision detector in the power-to-dBm chain.
- For each sample it finds the leading-one bit index and the next FRAC_W bits below it.
- It also emits the concatenation {position, fraction} as a Mitchell-style log2 estimate.
- It sits between the power accumulator and the dBm scaling block. It carries a sideband tag so multi-channel streams stay aligned.

Parameters:
DATA_W, 32, input sample width; must be a multiple of GROUP_W, min 8.
GROUP_W, 4, bits per coarse OR group (coarse search granularity).
FRAC_W, 4, fraction bits returned below the leading one; 1..DATA_W-1.
TAG_W, 8, sideband tag width, passed through unchanged.
(local) POS_W = clog2(DATA_W); NGRP = DATA_W/GROUP_W.

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  asynchronous, active-high reset
valid_in  in  1  input sample valid
ready_in  out  1  block can accept a sample this cycle
power_in  in  DATA_W  unsigned power sample
tag_in  in  TAG_W  channel/sequence tag
valid_out  out  1  result valid
ready_out  in  1  downstream accepts result this cycle
position_integer  out  POS_W  bit index of leading one (0-based)
precision  out  FRAC_W  FRAC_W bits immediately below leading one
log2_out  out  POS_W+FRAC_W  {position_integer, precision}
zero_out  out  1  input was zero
tag_out  out  TAG_W  tag of the sample producing this result

Behaviour:
- Reset (async assert, sync deassert externally guaranteed): all stage valid bits = 0, all data outputs = 0, valid_out = 0, ready_in = 1 after reset.
- Pipeline: 4 register stages, latency exactly 4 cycles from accepted input to valid_out when not stalled. Throughput is 1 sample per cycle.
  - S1: capture power, tag, valid on accept (valid_in & ready_in).
  - S2: NGRP group-OR flags, plus power and tag delayed.
  - S3: coarse priority encode. Highest nonzero group g; window = bits [g*GROUP_W+GROUP_W-1 down to g*GROUP_W-FRAC_W], zero-padded where the index is < 0. Also register base = g*GROUP_W.
  - S4: fine priority on the top GROUP_W window bits gives offset k. position = base+k; precision = the FRAC_W window bits directly below the leading one, zero-padded at the LSB end.
- Handshake: global stall.
  - adv = ~valid_out | ready_out; ready_in = adv.
  - When adv = 0, every stage holds (data and valid). No sample is dropped or duplicated, and order is preserved.
  - Bubbles propagate as valid = 0; data in invalid stages is don't-care, but outputs are only checked when valid_out = 1.
  - valid_out and the data outputs stay stable while valid_out & ~ready_out.
- Zero input: zero_out = 1, position_integer = 0, precision = 0, log2_out = 0.
- Nonzero input: zero_out = 0.
- MSB at bit 0: position 0, precision 0.
- MSB below FRAC_W: missing low bits are zeros (no wrap from the top bits).
- MSB in the top group: no overflow; max position = DATA_W-1.
- valid_in while ready_in = 0: ignored; the source must hold the sample.
- Reset mid-stream: all in-flight samples are discarded. First output after release corresponds to the first sample accepted after release.

Test Plan:
- Defaults, power_in = 0x0000_0B40, tag 0x11, ready_out = 1 -> 4 cycles later: valid_out, position_integer = 11, precision = 4'b0110, log2_out = 182, zero_out = 0, tag_out = 0x11.
- Edges: 0x0000_0001 -> pos 0, prec 0. 0x0000_0005 -> pos 2, prec 4'b0100. 0x8000_0000 -> pos 31, prec 0. 0xFFFF_FFFF -> pos 31, prec 4'b1111. 0 -> zero_out = 1, all else 0.
- Back-to-back stream of 16 random samples, with ready_out low on cycles 5-7 and 10 -> valid_out held stable during stalls, ready_in low during stalls, all 16 results in order vs reference model, no duplicates.
- valid_in toggling 1,0,1,0 with ready_out = 1 -> results spaced identically, valid_out pattern delayed by exactly 4 cycles.
- Assert rst for 1 cycle while 3 samples are in flight -> valid_out = 0 immediately (async), outputs 0. Next accepted sample appears 4 cycles after acceptance with the correct value.
- Parameter sweep DATA_W = 16, GROUP_W = 8, FRAC_W = 6: power_in = 0x0103 -> pos 8, prec 6'b000000. 0x00C0 -> pos 7, prec 6'b100000. Random compare against model for 1000 samples.
